// File: rtl/glove_coord_scheduler.sv
// glove_coord_scheduler: per-period sequencer for the glove pixel-to-mm datapath.
// Time-shares one converter across four axis jobs and commits results atomically.
module glove_coord_scheduler #(
    parameter int UPDATE_PERIOD = 210937,
    parameter int TIMEOUT       = 255,
    parameter int INIT_X1       = 2000,
    parameter int INIT_X2       = 8000,
    parameter int INIT_Y        = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  rel_glove1x,
    input  logic [9:0]  rel_glove1y,
    input  logic [9:0]  rel_glove2x,
    input  logic [9:0]  rel_glove2y,
    input  logic        glove_valid,
    output logic        conv_start,
    output logic [9:0]  conv_in,
    output logic        conv_axis,
    input  logic        conv_done,
    input  logic [15:0] conv_result,
    output logic [15:0] glob_glove1x,
    output logic [15:0] glob_glove1y,
    output logic [15:0] glob_glove2x,
    output logic [15:0] glob_glove2y,
    output logic        coords_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int CW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [CW-1:0] PER_LAST = CW'(UPDATE_PERIOD - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_job;
    logic [7:0]    r_to;
    logic [9:0]    r_snap_g1y;
    logic [9:0]    r_snap_g2x;
    logic [9:0]    r_snap_g2y;
    logic [15:0]   r_sh_g1x;
    logic [15:0]   r_sh_g1y;
    logic [15:0]   r_sh_g2x;
    logic          w_tick;
    logic [9:0]    w_next_in;

    assign w_tick = (r_cnt == '0);
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= PER_LAST;
        end else if (w_tick) begin
            r_cnt <= PER_LAST;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Glove1 x goes straight from the input port, so only jobs 1..3 need a snapshot.
    always_comb begin
        case (r_job)
            2'd0:    w_next_in = r_snap_g1y;
            2'd1:    w_next_in = r_snap_g2x;
            default: w_next_in = r_snap_g2y;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_job        <= 2'd0;
            r_to         <= 8'd0;
            r_snap_g1y   <= 10'd0;
            r_snap_g2x   <= 10'd0;
            r_snap_g2y   <= 10'd0;
            r_sh_g1x     <= 16'd0;
            r_sh_g1y     <= 16'd0;
            r_sh_g2x     <= 16'd0;
            conv_start   <= 1'b0;
            conv_in      <= 10'd0;
            conv_axis    <= 1'b0;
            glob_glove1x <= 16'(INIT_X1);
            glob_glove1y <= 16'(INIT_Y);
            glob_glove2x <= 16'(INIT_X2);
            glob_glove2y <= 16'(INIT_Y);
            coords_valid <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            conv_start   <= 1'b0;
            coords_valid <= 1'b0;
            if (w_tick && (r_state != S_IDLE)) begin
                overrun_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick && glove_valid) begin
                        r_snap_g1y <= rel_glove1y;
                        r_snap_g2x <= rel_glove2x;
                        r_snap_g2y <= rel_glove2y;
                        r_job      <= 2'd0;
                        conv_in    <= rel_glove1x;
                        conv_axis  <= 1'b0;
                        conv_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_to    <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        if (r_job != 2'd3) begin
                            case (r_job)
                                2'd0:    r_sh_g1x <= conv_result;
                                2'd1:    r_sh_g1y <= conv_result;
                                default: r_sh_g2x <= conv_result;
                            endcase
                            r_job      <= r_job + 2'd1;
                            conv_in    <= w_next_in;
                            conv_axis  <= ~r_job[0];
                            conv_start <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            glob_glove1x <= r_sh_g1x;
                            glob_glove1y <= r_sh_g1y;
                            glob_glove2x <= r_sh_g2x;
                            glob_glove2y <= conv_result;
                            coords_valid <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end else if (r_to == TO_LAST) begin
                        timeout_err <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_to <= r_to + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glove_coord_scheduler.sv
// Bench for glove_coord_scheduler: scenario table, reset-in-flight sequence and
// randomized traffic, all checked each cycle against a transaction-timing model.
module tb_glove_coord_scheduler;

    localparam int PER = 20;
    localparam int TO  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rel_glove1x = '0;
    logic [9:0]  rel_glove1y = '0;
    logic [9:0]  rel_glove2x = '0;
    logic [9:0]  rel_glove2y = '0;
    logic        glove_valid = 1'b0;
    logic        conv_start;
    logic [9:0]  conv_in;
    logic        conv_axis;
    logic        conv_done = 1'b0;
    logic [15:0] conv_result = '0;
    logic [15:0] glob_glove1x;
    logic [15:0] glob_glove1y;
    logic [15:0] glob_glove2x;
    logic [15:0] glob_glove2y;
    logic        coords_valid;
    logic        busy;
    logic        timeout_err;
    logic        overrun_err;

    always #5 clk = ~clk;

    glove_coord_scheduler #(
        .UPDATE_PERIOD(PER),
        .TIMEOUT(TO),
        .INIT_X1(2000),
        .INIT_X2(8000),
        .INIT_Y(2000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rel_glove1x(rel_glove1x),
        .rel_glove1y(rel_glove1y),
        .rel_glove2x(rel_glove2x),
        .rel_glove2y(rel_glove2y),
        .glove_valid(glove_valid),
        .conv_start(conv_start),
        .conv_in(conv_in),
        .conv_axis(conv_axis),
        .conv_done(conv_done),
        .conv_result(conv_result),
        .glob_glove1x(glob_glove1x),
        .glob_glove1y(glob_glove1y),
        .glob_glove2x(glob_glove2x),
        .glob_glove2y(glob_glove2y),
        .coords_valid(coords_valid),
        .busy(busy),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    typedef struct {
        logic [3:0][9:0]  rel;
        int               lat;
        int               hold;
        int               glitch;
        logic             gv;
        logic [3:0][15:0] eg;
        int               cv_at;
        logic             to;
        logic             ov;
        int               starts;
        int               run;
    } vec_t;

    vec_t vt[8];

    int n;
    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0][9:0] s_rel;
    logic            s_gv;
    int              s_lat;
    int              s_hold;
    bit              s_rand;

    bit          c_pend;
    int          c_due;
    logic [15:0] c_res;
    int          c_starts;

    bit               m_act;
    int               m_job;
    int               m_start;
    logic [3:0][9:0]  m_snap;
    logic [2:0][15:0] m_sh;
    logic             e_cs, e_ax, e_cv, e_to, e_ov;
    logic [9:0]       e_in;
    logic [3:0][15:0] e_g;

    int cv_first;
    int cv_cnt;

    function automatic vec_t mk(input int r0, r1, r2, r3,
                                input int lat, hold, glitch,
                                input logic gv,
                                input int g0, g1, g2, g3,
                                input int cv_at,
                                input logic to, ov,
                                input int starts, run);
        vec_t v;
        v.rel[0] = 10'(r0);
        v.rel[1] = 10'(r1);
        v.rel[2] = 10'(r2);
        v.rel[3] = 10'(r3);
        v.lat    = lat;
        v.hold   = hold;
        v.glitch = glitch;
        v.gv     = gv;
        v.eg[0]  = 16'(g0);
        v.eg[1]  = 16'(g1);
        v.eg[2]  = 16'(g2);
        v.eg[3]  = 16'(g3);
        v.cv_at  = cv_at;
        v.to     = to;
        v.ov     = ov;
        v.starts = starts;
        v.run    = run;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, n, got, want);
        end
    endtask

    task automatic model_reset();
        m_act    = 0;
        m_job    = 0;
        m_start  = 0;
        m_sh     = '0;
        m_snap   = '0;
        e_cs     = 0;
        e_ax     = 0;
        e_cv     = 0;
        e_to     = 0;
        e_ov     = 0;
        e_in     = '0;
        e_g[0]   = 16'd2000;
        e_g[1]   = 16'd2000;
        e_g[2]   = 16'd8000;
        e_g[3]   = 16'd2000;
        c_pend   = 0;
        c_due    = 0;
        c_res    = '0;
        c_starts = 0;
        cv_first = -1;
        cv_cnt   = 0;
    endtask

    // Frame timing: job issued at m_start, waiting starts the cycle after.
    task automatic model_step(input logic done, input logic [15:0] res);
        bit tick;
        tick = (n % PER) == (PER - 1);
        e_cs = 0;
        e_cv = 0;
        if (m_act) begin
            if (tick) e_ov = 1;
            if (done && n > m_start) begin
                if (m_job < 3) begin
                    m_sh[m_job] = res;
                    m_job++;
                    m_start = n + 1;
                    e_cs = 1;
                    e_in = m_snap[m_job];
                    e_ax = (m_job % 2) == 1;
                end else begin
                    e_g[0] = m_sh[0];
                    e_g[1] = m_sh[1];
                    e_g[2] = m_sh[2];
                    e_g[3] = res;
                    e_cv = 1;
                    m_act = 0;
                end
            end else if (n - m_start == TO) begin
                e_to = 1;
                m_act = 0;
            end
        end else if (tick && s_gv) begin
            m_act = 1;
            m_snap = s_rel;
            m_job = 0;
            m_start = n + 1;
            e_cs = 1;
            e_in = s_rel[0];
            e_ax = 0;
        end
    endtask

    task automatic check_outs();
        chk("conv_start", 32'(conv_start), 32'(e_cs));
        chk("conv_in", 32'(conv_in), 32'(e_in));
        chk("conv_axis", 32'(conv_axis), 32'(e_ax));
        chk("coords_valid", 32'(coords_valid), 32'(e_cv));
        chk("busy", 32'(busy), 32'(m_act));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("overrun_err", 32'(overrun_err), 32'(e_ov));
        chk("glob_glove1x", 32'(glob_glove1x), 32'(e_g[0]));
        chk("glob_glove1y", 32'(glob_glove1y), 32'(e_g[1]));
        chk("glob_glove2x", 32'(glob_glove2x), 32'(e_g[2]));
        chk("glob_glove2y", 32'(glob_glove2y), 32'(e_g[3]));
    endtask

    function automatic int pick_lat();
        if ($urandom_range(0, 19) == 0) return TO + 5;
        return int'($urandom_range(1, 6));
    endfunction

    task automatic step();
        logic d;
        logic [15:0] r;
        check_outs();
        if (coords_valid === 1'b1) begin
            cv_cnt++;
            if (cv_first < 0) cv_first = n;
        end
        if (conv_start === 1'b1) begin
            c_starts++;
            c_pend = (c_starts - 1) != s_hold;
            c_due = n + (s_rand ? pick_lat() : s_lat);
            c_res = 16'(conv_in) * 16'd10;
        end
        d = 1'b0;
        r = 16'($urandom);
        if (c_pend && n == c_due) begin
            d = 1'b1;
            r = c_res;
            c_pend = 0;
        end else if (s_rand && $urandom_range(0, 15) == 0
                     && !(m_act && n > m_start)) begin
            d = 1'b1;
        end
        rel_glove1x = s_rel[0];
        rel_glove1y = s_rel[1];
        rel_glove2x = s_rel[2];
        rel_glove2y = s_rel[3];
        glove_valid = s_gv;
        conv_done   = d;
        conv_result = r;
        model_step(d, r);
        @(negedge clk);
        n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        conv_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
    endtask

    initial begin
        vt[0] = mk(100, 200, 300, 400, 1, -1, 0, 1'b0,
                   2000, 2000, 8000, 2000, -1, 1'b0, 1'b0, 0, 60);
        vt[1] = mk(100, 200, 300, 400, 1, -1, 0, 1'b1,
                   1000, 2000, 3000, 4000, 9, 1'b0, 1'b0, 4, 30);
        vt[2] = mk(100, 200, 300, 400, 1, -1, 2, 1'b1,
                   1000, 2000, 3000, 4000, 9, 1'b0, 1'b0, 4, 30);
        vt[3] = mk(100, 200, 300, 400, 1, 2, 0, 1'b1,
                   1000, 2000, 3000, 4000, 69, 1'b1, 1'b1, 7, 95);
        vt[4] = mk(7, 8, 9, 1023, 30, -1, 0, 1'b1,
                   70, 80, 90, 10230, 125, 1'b0, 1'b1, 4, 150);
        vt[5] = mk(0, 1023, 512, 1, 3, -1, 0, 1'b1,
                   0, 10230, 5120, 10, 17, 1'b0, 1'b0, 4, 40);
        vt[6] = mk(11, 22, 33, 44, TO, -1, 0, 1'b1,
                   110, 220, 330, 440, 165, 1'b0, 1'b1, 4, 190);
        vt[7] = mk(50, 60, 70, 80, TO + 1, -1, 0, 1'b1,
                   2000, 2000, 8000, 2000, -1, 1'b1, 1'b1, 2, 100);

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            int cv_rel;
            do_reset();
            s_rel  = vt[i].rel;
            s_gv   = vt[i].gv;
            s_lat  = vt[i].lat;
            s_hold = vt[i].hold;
            s_rand = 0;
            for (int k = 0; k < vt[i].run; k++) begin
                if (vt[i].glitch > 0 && n == (PER - 1) + vt[i].glitch) begin
                    s_rel = {4{10'd5}};
                end
                step();
            end
            cv_rel = (cv_first < 0) ? -1 : cv_first - (PER - 1);
            chk("tbl_g1x", 32'(glob_glove1x), 32'(vt[i].eg[0]));
            chk("tbl_g1y", 32'(glob_glove1y), 32'(vt[i].eg[1]));
            chk("tbl_g2x", 32'(glob_glove2x), 32'(vt[i].eg[2]));
            chk("tbl_g2y", 32'(glob_glove2y), 32'(vt[i].eg[3]));
            chk("tbl_cv_at", 32'(cv_rel), 32'(vt[i].cv_at));
            chk("tbl_timeout", 32'(timeout_err), 32'(vt[i].to));
            chk("tbl_overrun", 32'(overrun_err), 32'(vt[i].ov));
            chk("tbl_starts", 32'(c_starts), 32'(vt[i].starts));
        end

        // Reset landing while job 1 is outstanding.
        do_reset();
        s_rel[0] = 10'd21;
        s_rel[1] = 10'd22;
        s_rel[2] = 10'd23;
        s_rel[3] = 10'd24;
        s_gv   = 1'b1;
        s_lat  = 1;
        s_hold = -1;
        s_rand = 0;
        while (n < 30) step();
        chk("pre_g1x", 32'(glob_glove1x), 32'd210);
        chk("pre_g2y", 32'(glob_glove2y), 32'd240);
        s_lat = 5;
        while (n < 48) step();
        chk("pre_busy", 32'(busy), 32'd1);
        chk("pre_in", 32'(conv_in), 32'd22);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(conv_start), 32'd0);
        chk("rst_in", 32'(conv_in), 32'd0);
        chk("rst_axis", 32'(conv_axis), 32'd0);
        chk("rst_g1x", 32'(glob_glove1x), 32'd2000);
        chk("rst_g1y", 32'(glob_glove1y), 32'd2000);
        chk("rst_g2x", 32'(glob_glove2x), 32'd8000);
        chk("rst_g2y", 32'(glob_glove2y), 32'd2000);
        @(negedge clk);
        s_lat = 1;
        do_reset();
        while (n < 20) step();
        chk("restart_start", 32'(conv_start), 32'd1);
        chk("restart_in", 32'(conv_in), 32'd21);
        chk("restart_axis", 32'(conv_axis), 32'd0);
        while (n < 40) step();
        chk("restart_g1x", 32'(glob_glove1x), 32'd210);

        // Randomized traffic with variable latency, timeouts and stray dones.
        do_reset();
        s_rand = 1;
        s_hold = -1;
        for (int k = 0; k < 3000; k++) begin
            s_rel[0] = 10'($urandom);
            s_rel[1] = 10'($urandom);
            s_rel[2] = 10'($urandom);
            s_rel[3] = 10'($urandom);
            s_gv = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/glove_coord_scheduler.md
Name: glove_coord_scheduler

Overview:
- Sequences the glove-coordinate conversion datapath once per update period.
- Snapshots the four relative glove positions from hand tracking.
- Shares one pixel-to-millimetre converter among the four axis jobs (glove1 x, glove1 y, glove2 x, glove2 y) using a start/done handshake.
- Commits all four global coordinates atomically to the game logic, with a one-cycle valid strobe.

Parameters:
- UPDATE_PERIOD, 210937: clock cycles between update ticks.
- TIMEOUT, 255: maximum cycles to wait for conv_done after conv_start.
- INIT_X1, 2000: reset value of glob_glove1x (mm).
- INIT_X2, 8000: reset value of glob_glove2x (mm).
- INIT_Y, 2000: reset value of glob_glove1y and glob_glove2y (mm).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rel_glove1x  in  10  glove1 x position, camera pixels
- rel_glove1y  in  10  glove1 y position, camera pixels
- rel_glove2x  in  10  glove2 x position, camera pixels
- rel_glove2y  in  10  glove2 y position, camera pixels
- glove_valid  in  1  tracking positions are current
- conv_start  out  1  one-cycle request to the converter
- conv_in  out  10  pixel value presented to the converter
- conv_axis  out  1  0 = x, 1 = y
- conv_done  in  1  converter result valid, one-cycle pulse
- conv_result  in  16  converted value, mm
- glob_glove1x  out  16  committed global coordinate, mm
- glob_glove1y  out  16  committed global coordinate, mm
- glob_glove2x  out  16  committed global coordinate, mm
- glob_glove2y  out  16  committed global coordinate, mm
- coords_valid  out  1  one-cycle strobe: new coordinates committed
- busy  out  1  high while state is not IDLE
- timeout_err  out  1  sticky; converter failed to respond
- overrun_err  out  1  sticky; tick arrived while busy

Behaviour:
- Reset (asynchronous):
  - Period counter = UPDATE_PERIOD-1; state = IDLE; job index = 0.
  - Globals = INIT_X1, INIT_Y, INIT_X2, INIT_Y.
  - conv_start, coords_valid, busy, timeout_err, overrun_err = 0.
  - conv_in = 0; conv_axis = 0.
- Period counter:
  - Free-running down-counter; reloads UPDATE_PERIOD-1 after 0.
  - tick = (counter == 0). The counter never stalls.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - On tick with glove_valid=1: snapshot all four rel inputs into internal registers, set job=0, go to ISSUE.
  - On tick with glove_valid=0: stay in IDLE, no update.
  - conv_done received in IDLE is ignored.
- ISSUE (exactly 1 cycle):
  - conv_start=1.
  - conv_in = snapshot[job]; job order is 0=g1x, 1=g1y, 2=g2x, 3=g2y.
  - conv_axis = job[0].
  - Clear the timeout counter; go to WAIT.
  - conv_done during ISSUE is ignored.
- WAIT:
  - conv_in and conv_axis hold their values.
  - On conv_done: write conv_result to shadow[job].
    - If job<3: job+1, go to ISSUE.
    - If job==3: next cycle all four glob outputs load their shadow values (job 3 takes conv_result directly), coords_valid=1 for exactly that cycle, and state returns to IDLE.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT without conv_done: abort the frame, discard shadows, leave globals unchanged, set timeout_err, go to IDLE.
- Snapshot rule: rel inputs are sampled only at the accepting tick; input changes mid-frame have no effect.
- Overrun: a tick while state != IDLE sets overrun_err and is dropped. The frame in progress continues.
- Sticky flags clear only on reset.
- Latency: with converter latency L (conv_done L cycles after conv_start, L≥1) and tick at cycle T, coords_valid occurs at T + 4(L+1) + 1. For L=1 that is T+9.
- Outputs never change except on a coords_valid cycle or reset.
- Reset mid-frame: immediate return to the reset values above; the partial frame is discarded.
- Widths: conv_result is stored unmodified (16-bit, no saturation). The timeout counter is 8 bits wide, sufficient for TIMEOUT≤255.

Test Plan:
- Reset then idle with UPDATE_PERIOD=20 and glove_valid=0 -> no conv_start ever; globals stay 2000/2000/8000/2000; coords_valid never asserted.
- UPDATE_PERIOD=20, rel = 100/200/300/400, converter model returns in*10 with L=1 -> conv_in sequence 100,200,300,400 with axis 0,1,0,1; coords_valid 9 cycles after tick; globals 1000/2000/3000/4000.
- Same setup, change rel inputs to 5/5/5/5 two cycles after the tick -> committed globals still 1000/2000/3000/4000.
- Converter withholds done on job 2, TIMEOUT=10 -> timeout_err=1 after 10 WAIT cycles; globals unchanged; the next tick with a good converter commits normally.
- Converter L=30, UPDATE_PERIOD=20 -> overrun_err=1; the frame still commits correct values; extra ticks produce no additional conv_start.
- Assert reset while in WAIT on job 1 -> all outputs return to reset values immediately; busy=0; the next tick restarts at job 0.
